sd_sector_client: RTL
=====================

Name: sd_sector_client

Overview:
- Core-side requester that sits directly upstream of the SD card wrapper, on one of its four request channels.
- Accepts a read/write request for one 512-byte sector from a core disk controller (floppy or ACSI) and checks it against the mounted image size.
- Holds the matching rstart/wstart bit until the wrapper reports done, and moves sector data between the wrapper's byte stream and a private 512-byte buffer.
- The core accesses that buffer at any rate through a simple RAM port.

Parameters:
- CHANNEL, 0, request bit index 0..3 driven on sd_rstart/sd_wstart.
- TIMEOUT, 32'd50_000_000, clk cycles allowed from request issue to sd_rdone before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset; 1 = working, 0 = reset
- mount_strobe  in  1  one-cycle pulse: image on this channel (re)mounted
- mount_size  in  32  image size in bytes, sampled on mount_strobe
- req_rd  in  1  one-cycle pulse: read sector req_sector into buffer
- req_wr  in  1  one-cycle pulse: write buffer to sector req_sector
- req_sector  in  32  logical sector number, sampled with req_*
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- err  out  1  status of last request (1 = rejected or timed out); valid from done
- mounted  out  1  image present (mount_size != 0)
- buf_addr  in  9  core buffer address
- buf_we  in  1  core buffer write enable
- buf_din  in  8  core write data
- buf_dout  out  8  core read data, 1-cycle latency
- sd_rstart  out  4  read request to wrapper; only bit CHANNEL is ever driven
- sd_wstart  out  4  write request to wrapper; only bit CHANNEL is ever driven
- sd_rsector  out  32  sector number presented to wrapper
- sd_rbusy  in  1  wrapper busy (status only)
- sd_rdone  in  1  wrapper completion pulse
- sd_outen  in  1  read byte valid
- sd_outaddr  in  9  byte index 0..511; during writes this is also the index being fetched
- sd_outbyte  in  8  read byte
- sd_inbyte  out  8  write byte, registered one cycle after sd_outaddr

Behaviour:
- Reset values (rstn=0, synchronous):
  - state=IDLE.
  - sd_rstart=sd_wstart=0, sd_rsector=0.
  - busy=done=err=0, mounted=0.
  - Latched image sector count = 0.
  - Buffer contents are not cleared.
- Image size:
  - On mount_strobe, latch sectors = mount_size[31:9] (partial trailing sector ignored) and set mounted = (mount_size != 0).
  - mount_strobe while busy: take effect immediately for the next request; the current request is not aborted.
- States: IDLE, RD_WAIT, WR_WAIT, FINISH.
- IDLE:
  - req_rd (req_rd wins if both req_rd and req_wr are set): latch req_sector into sd_rsector.
  - If !mounted or req_sector >= sectors (unsigned, 32-bit compare against the zero-extended count): go to FINISH with err=1; no SD request is issued.
  - Otherwise go to RD_WAIT, or WR_WAIT for req_wr.
  - busy=1 from the cycle after the request through the FINISH cycle.
- RD_WAIT / WR_WAIT:
  - sd_rstart[CHANNEL] (resp. sd_wstart[CHANNEL]) is held high continuously; the wrapper raises its IRQ on the rising edge and clears its internal start on done.
  - Timeout counter is cleared on entry and counts every clk.
  - On sd_rdone: drop the start bit the same cycle it is seen (registered, low from the next cycle), err=0, go to FINISH.
  - If the counter reaches TIMEOUT first (TIMEOUT != 0): drop the start bit, err=1, go to FINISH. Any later sd_rdone is ignored while in IDLE.
- FINISH: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Requests arriving while not in IDLE are ignored (no queueing).
- Buffer: dual-port 512x8 RAM.
  - Port A (SD side): address sd_outaddr. Writes sd_outbyte when sd_outen && state==RD_WAIT; sd_outen in any other state is ignored. Read data drives sd_inbyte with one-cycle latency.
  - Port B (core side): buf_addr/buf_we/buf_din/buf_dout. buf_we is honoured only in IDLE and ignored while busy; reads are always allowed but undefined during RD_WAIT.
  - Same-address same-cycle collision on the two ports: the port-A write wins and port-B read data is undefined.
- sd_rbusy is not used for sequencing.
- rstn low mid-request: start bits drop on the next edge; no done pulse is generated.

Test Plan:
- Mount 1 MiB (mount_size=32'h0010_0000 → 2048 sectors).
  - req_rd sector 5 → sd_rstart=1<<CHANNEL and sd_rsector=5 next cycle.
  - Model streams bytes i^8'hA5 on sd_outaddr=i with sd_outen, then pulses sd_rdone → start low, done=1 one cycle, err=0.
  - buf_dout at addr 0x1FF reads 8'h5A.
- Core writes buf[i]=i[7:0], then req_wr sector 2047 → sd_wstart held.
  - Model sweeps sd_outaddr 0..511; sd_inbyte equals addr[7:0] one cycle later.
  - sd_rdone → done=1, err=0.
- req_rd sector 2048 with 2048 sectors mounted → no start bit asserted, done=1 within 2 cycles, err=1.
- No mount (or mount_size=0) plus req_wr → err=1. Also, mount_size=511 gives mounted=1 but sectors=0, so req_rd sector 0 → err=1.
- TIMEOUT=100, req_rd with no sd_rdone → start dropped at cycle 100, done with err=1; a late sd_rdone causes no further done pulse.
- Corner cases:
  - rstn low during RD_WAIT → start=0, busy=0, no done.
  - req_rd and req_wr in the same cycle → read issued.
  - buf_we while busy → buffer unchanged.

Source files
------------

// File: rtl/sd_sector_client.sv
// Single-sector requester on one SD wrapper channel: checks each request against the
// mounted image, holds the channel's start bit until done, and buffers the sector.
module sd_sector_client #(
   parameter int unsigned CHANNEL = 0,
   parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        mount_strobe_i,
   input  logic [31:0] mount_size_i,
   input  logic        req_rd_i,
   input  logic        req_wr_i,
   input  logic [31:0] req_sector_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        mounted_o,
   input  logic [8:0]  buf_addr_i,
   input  logic        buf_we_i,
   input  logic [7:0]  buf_din_i,
   output logic [7:0]  buf_dout_o,
   output logic [3:0]  sd_rstart_o,
   output logic [3:0]  sd_wstart_o,
   output logic [31:0] sd_rsector_o,
   input  logic        sd_rbusy_i,
   input  logic        sd_rdone_i,
   input  logic        sd_outen_i,
   input  logic [8:0]  sd_outaddr_i,
   input  logic [7:0]  sd_outbyte_i,
   output logic [7:0]  sd_inbyte_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      FINISH  = 2'd3
   } state_t;

   localparam logic [3:0] CH_MASK = 4'(4'b0001 << CHANNEL);

   state_t      state_q, state_d;
   logic [22:0] sectors_q, sectors_d;
   logic        mounted_q, mounted_d;
   logic [31:0] rsector_q, rsector_d;
   logic        rstart_q, rstart_d;
   logic        wstart_q, wstart_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] tmo_q, tmo_d;
   logic [7:0]  mem_q [0:511];
   logic [7:0]  sd_inbyte_q;
   logic [7:0]  buf_dout_q;

   logic        req_any_s;
   logic        reject_s;
   logic        waiting_s;
   logic        timeout_s;
   logic        unused_s;

   assign req_any_s = req_rd_i | req_wr_i;
   assign reject_s  = !mounted_q || (req_sector_i >= {9'd0, sectors_q});
   assign waiting_s = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   assign timeout_s = (TIMEOUT != 32'd0) && (tmo_q == (TIMEOUT - 32'd1));
   assign unused_s  = sd_rbusy_i;

   // State and control registers
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         sectors_q <= 23'd0;
         mounted_q <= 1'b0;
         rsector_q <= 32'd0;
         rstart_q  <= 1'b0;
         wstart_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         sectors_q <= sectors_d;
         mounted_q <= mounted_d;
         rsector_q <= rsector_d;
         rstart_q  <= rstart_d;
         wstart_q  <= wstart_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_any_s) begin
               if (reject_s) begin
                  state_d = FINISH;
               end else if (req_rd_i) begin
                  state_d = RD_WAIT;
               end else begin
                  state_d = WR_WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (sd_rdone_i || timeout_s) begin
               state_d = FINISH;
            end else begin
               state_d = state_q;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Register next values; start bits and flags follow the upcoming state
   always_comb begin
      sectors_d = sectors_q;
      mounted_d = mounted_q;
      rsector_d = rsector_q;
      err_d     = err_q;
      rstart_d  = (state_d == RD_WAIT);
      wstart_d  = (state_d == WR_WAIT);
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == FINISH);
      if (waiting_s) begin
         tmo_d = tmo_q + 32'd1;
      end else begin
         tmo_d = 32'd0;
      end
      if (mount_strobe_i) begin
         sectors_d = mount_size_i[31:9];
         mounted_d = (mount_size_i != 32'd0);
      end else begin
         sectors_d = sectors_q;
         mounted_d = mounted_q;
      end
      case (state_q)
         IDLE: begin
            if (req_any_s) begin
               rsector_d = req_sector_i;
               err_d     = reject_s;
            end else begin
               rsector_d = rsector_q;
               err_d     = err_q;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (sd_rdone_i) begin
               err_d = 1'b0;
            end else if (timeout_s) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         default: err_d = err_q;
      endcase
   end

   // Sector buffer writes: SD side only while reading, core side only when idle
   always_ff @(posedge clk_i) begin
      if (sd_outen_i && (state_q == RD_WAIT)) begin
         mem_q[sd_outaddr_i] <= sd_outbyte_i;
      end else if (buf_we_i && (state_q == IDLE)) begin
         mem_q[buf_addr_i] <= buf_din_i;
      end
   end

   // Sector buffer read ports
   always_ff @(posedge clk_i) begin
      sd_inbyte_q <= mem_q[sd_outaddr_i];
      buf_dout_q  <= mem_q[buf_addr_i];
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign mounted_o    = mounted_q;
   assign sd_rstart_o  = rstart_q ? CH_MASK : 4'd0;
   assign sd_wstart_o  = wstart_q ? CH_MASK : 4'd0;
   assign sd_rsector_o = rsector_q;
   assign sd_inbyte_o  = sd_inbyte_q;
   assign buf_dout_o   = buf_dout_q;

endmodule
